ifu_fetch: RTL and testbench

- Multi-cycle instruction fetch unit that sits directly upstream of the npc decode/execute datapath.
- Owns the PC and issues one instruction read per instruction on a valid/ready memory read channel.
- Hands the fetched word to decode over a valid/ready handshake, then waits for the executed next_pc before fetching again.
- Detects misaligned PCs, bus errors and unanswered reads, and reports them as a sticky fault.

---
 rtl/ifu_fetch.sv | 177 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: multi-cycle instruction fetch unit feeding the decode/execute path.
//
// The unit owns the PC and issues one read for each instruction on a
// valid/ready memory read channel. It passes the returned word to decode over
// a valid/ready handshake. It then waits for execute to supply the next PC.
// A misaligned PC, a bus error response, or a read that gets no answer within
// TIMEOUT cycles latches a sticky fault. The unit stays in that fault until
// reset.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   mem_ar*           read address channel (araddr = pc)
//   mem_r*            read data channel (rresp 00 = OKAY)
//   inst, inst_pc     fetched word and its PC, qualified by inst_valid/inst_ready
//   npc, npc_valid    next PC from execute, single-cycle pulse
//   pc                current PC register
//   fault*            sticky fault flag, cause (01 misalign, 10 bus, 11 timeout), PC
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] mem_araddr,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic [31:0] npc,
  input  logic        npc_valid,
  output logic [31:0] pc,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_pc
);

  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_R, S_OUT, S_WAIT_PC, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_BUS      = 2'b10,
    CAUSE_TIMEOUT  = 2'b11
  } cause_e;

  typedef struct packed {
    logic        valid;
    cause_e      cause;
    logic [31:0] pc;
  } fault_t;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic [31:0] tmo_q, tmo_d;
  fault_t      fault_q, fault_d;

  logic        take_fault;
  cause_e      cause;
  logic        tmo_hit;
  logic        pc_misaligned;
  logic        r_hs;

  assign pc_misaligned = (pc_q[1:0] != 2'b00);
  assign r_hs          = mem_rvalid;  // only sampled in WAIT_R, where rready=1
  // Last allowed cycle of the fetch window; fires on the TIMEOUT-th cycle.
  assign tmo_hit       = TMO_EN && (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    tmo_d      = tmo_q;
    fault_d    = fault_q;
    take_fault = 1'b0;
    cause      = CAUSE_NONE;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        tmo_d   = '0;
      end
      S_REQ: begin
        if (pc_misaligned) begin
          take_fault = 1'b1;
          cause      = CAUSE_MISALIGN;
        end else if (tmo_hit) begin
          // Address acceptance alone does not stop the timeout; only read data does.
          take_fault = 1'b1;
          cause      = CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 32'd1;
          if (mem_arready) state_d = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (r_hs) begin
          // A data handshake takes priority over a timeout in the same cycle.
          if (mem_rresp == 2'b00) begin
            inst_d    = mem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_OUT;
          end else begin
            take_fault = 1'b1;
            cause      = CAUSE_BUS;
          end
        end else if (tmo_hit) begin
          take_fault = 1'b1;
          cause      = CAUSE_TIMEOUT;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end
      end
      S_OUT: begin
        if (inst_ready) state_d = S_WAIT_PC;
      end
      S_WAIT_PC: begin
        if (npc_valid) begin
          pc_d    = npc;
          tmo_d   = '0;
          state_d = S_REQ;
        end
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase

    if (take_fault) begin
      state_d = S_FAULT;
      fault_d = '{valid: 1'b1, cause: cause, pc: pc_q};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      tmo_q     <= '0;
      fault_q   <= '{valid: 1'b0, cause: CAUSE_NONE, pc: 32'h0};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      tmo_q     <= tmo_d;
      fault_q   <= fault_d;
    end
  end

  // A misaligned PC never reaches the bus, even during its single REQ cycle.
  assign mem_arvalid = (state_q == S_REQ) && !pc_misaligned;
  assign mem_araddr  = pc_q;
  assign mem_rready  = (state_q == S_WAIT_R);
  assign inst_valid  = (state_q == S_OUT);
  assign inst        = inst_q;
  assign inst_pc     = inst_pc_q;
  assign pc          = pc_q;
  assign fault       = fault_q.valid;
  assign fault_cause = fault_q.cause;
  assign fault_pc    = fault_q.pc;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: transaction-level model of the fetch loop (expected PC,
// memory contents by address, fault rules) driving randomized handshake delays.
module tb_ifu_fetch;
  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_araddr;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] npc;
  logic        npc_valid;
  logic [31:0] pc;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_pc;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_ar_hs = 0;
  int          exp_fetches = 0;
  logic [31:0] exp_pc;

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid),
    .mem_rready(mem_rready),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .npc(npc), .npc_valid(npc_valid), .pc(pc),
    .fault(fault), .fault_cause(fault_cause), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst && mem_arvalid && mem_arready) n_ar_hs++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Memory contents as seen by the model: one fixed word at the reset vector.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == RST_PC) ? 32'h0000_0413 : ((a ^ 32'h1357_9BDF) + 32'h0000_0013);
  endfunction

  // Holds reset for two edges, checks reset state, releases; ends in REQ.
  task automatic do_reset(input bit stale);
    rst = 1'b0;
    if (stale) begin
      mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0; mem_rresp = 2'b00;
    end
    step(); step();
    chk("rst_pc", pc, RST_PC);
    chk("rst_fault", {29'b0, fault, fault_cause}, 32'h0);
    chk("rst_fault_pc", fault_pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_hs_outs", {29'b0, mem_arvalid, mem_rready, inst_valid}, 32'h0);
    rst = 1'b1;
    step();
    chk("rel_rready", {31'b0, mem_rready}, 32'h0);
    exp_pc = RST_PC;
  endtask

  // One fetch starting at the first REQ cycle. aw/rw/iw are stall cycles on
  // arready, rvalid and inst_ready.
  task automatic fetch_one(input int aw, input int rw, input int iw, input logic [1:0] resp);
    int          hi = 0;
    bit          ok = 1'b1;
    logic [31:0] i0, p0;
    chk("pc", pc, exp_pc);
    for (int k = 0; k <= aw; k++) begin
      mem_arready = (k == aw);
      if (mem_arvalid) hi++;
      if (mem_araddr !== exp_pc || mem_rready) ok = 1'b0;
      step();
    end
    mem_arready = 1'b0;
    exp_fetches++;
    chk("ar_hold", hi, aw + 1);
    chk("ar_addr", {31'b0, ok}, 32'h1);
    ok = 1'b1;
    for (int k = 0; k <= rw; k++) begin
      mem_rvalid = (k == rw);
      mem_rdata  = mem_word(exp_pc);
      mem_rresp  = resp;
      if (!mem_rready || mem_arvalid) ok = 1'b0;
      step();
    end
    mem_rvalid = 1'b0;
    chk("rready", {31'b0, ok}, 32'h1);
    if (resp != 2'b00) begin
      chk("bus_fault", {30'b0, fault_cause}, {30'b0, fault, 1'b0});
      chk("bus_cause", {30'b0, fault_cause}, 32'h2);
      chk("bus_fault_pc", fault_pc, exp_pc);
      chk("bus_no_inst", {31'b0, inst_valid}, 32'h0);
      return;
    end
    i0 = inst; p0 = inst_pc; ok = 1'b1;
    for (int k = 0; k <= iw; k++) begin
      inst_ready = (k == iw);
      npc_valid  = (k == 0);            // must be ignored outside WAIT_PC
      npc        = 32'hDEAD_BEE0;
      if (!inst_valid || inst !== i0 || inst_pc !== p0) ok = 1'b0;
      step();
      npc_valid = 1'b0;
    end
    inst_ready = 1'b0;
    chk("inst", i0, mem_word(exp_pc));
    chk("inst_pc", p0, exp_pc);
    chk("out_stable", {31'b0, ok}, 32'h1);
    chk("out_drop", {31'b0, inst_valid}, 32'h0);
  endtask

  // In WAIT_PC: stay quiet for wp cycles, then pulse npc. Ends in REQ.
  task automatic give_npc(input logic [31:0] n, input int wp);
    bit ok = 1'b1;
    for (int k = 0; k < wp; k++) begin
      if (mem_arvalid || inst_valid || mem_rready) ok = 1'b0;
      step();
    end
    chk("wait_pc_quiet", {31'b0, ok}, 32'h1);
    npc = n; npc_valid = 1'b1;
    step();
    npc_valid = 1'b0;
    exp_pc = n;
  endtask

  task automatic check_fault_hold(input logic [1:0] c, input logic [31:0] fpc);
    npc = 32'h8000_0100; npc_valid = 1'b1; inst_ready = 1'b1;
    step(); npc_valid = 1'b0; inst_ready = 1'b0;
    step(); step();
    chk("hold_fault", {29'b0, fault, fault_cause}, {29'b0, 1'b1, c});
    chk("hold_fault_pc", fault_pc, fpc);
    chk("hold_outs", {29'b0, mem_arvalid, mem_rready, inst_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] n;
    rst = 1'b0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    mem_rresp = 2'b00; inst_ready = 1'b0; npc = '0; npc_valid = 1'b0;
    exp_pc = RST_PC;

    // Zero-wait first fetch: inst_valid lands on the third edge after release.
    do_reset(1'b0);
    fetch_one(0, 0, 0, 2'b00);
    give_npc(32'h8000_0004, 0);
    // Backpressure on arready then inst_ready.
    fetch_one(3, 0, 4, 2'b00);
    give_npc(exp_pc + 32'd4, 1);

    for (int t = 0; t < 20; t++) begin
      fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4), 2'b00);
      n = $urandom();
      n = $urandom_range(0, 1) ? exp_pc + 32'd4 : (n & 32'hFFFF_FFFC);
      give_npc(n, $urandom_range(0, 2));
    end

    // Top of address space, and data arriving on the last timeout cycle.
    fetch_one(0, 0, 0, 2'b00);
    give_npc(32'hFFFF_FFFC, 0);
    fetch_one(1, 5, 0, 2'b00);
    give_npc(32'h8000_0040, 0);

    // Read data never arrives: fault on the 8th edge after entering REQ.
    chk("tmo_pc", pc, exp_pc);
    for (int c = 0; c < 8; c++) begin
      mem_arready = (c == 1);
      if (c == 7) chk("tmo_not_yet", {30'b0, fault, mem_rready}, 32'h1);
      step();
    end
    mem_arready = 1'b0;
    exp_fetches++;
    chk("tmo_fault", {29'b0, fault, fault_cause}, 32'h7);
    chk("tmo_fault_pc", fault_pc, 32'h8000_0040);
    check_fault_hold(2'b11, 32'h8000_0040);

    // Bus error response.
    do_reset(1'b0);
    fetch_one(0, 0, 0, 2'b00);
    give_npc(32'h8000_0010, 0);
    fetch_one(1, 1, 0, 2'b10);
    check_fault_hold(2'b10, 32'h8000_0010);

    // Misaligned next PC: no request on the bus at all.
    do_reset(1'b0);
    fetch_one(0, 0, 0, 2'b00);
    give_npc(32'h8000_0006, 0);
    begin
      int hi = 0;
      mem_arready = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (mem_arvalid) hi++;
        step();
      end
      mem_arready = 1'b0;
      chk("mis_no_arvalid", hi, 0);
      chk("mis_fault", {29'b0, fault, fault_cause}, 32'h5);
      chk("mis_fault_pc", fault_pc, 32'h8000_0006);
    end
    check_fault_hold(2'b01, 32'h8000_0006);

    // Reset mid WAIT_R with a late, stale rvalid.
    do_reset(1'b0);
    mem_arready = 1'b1; step(); mem_arready = 1'b0;
    exp_fetches++;
    step();
    chk("mid_in_wait_r", {31'b0, mem_rready}, 32'h1);
    do_reset(1'b1);
    fetch_one(1, 1, 0, 2'b00);
    chk("after_stale_fault", {31'b0, fault}, 32'h0);

    chk("one_fetch_per_npc", n_ar_hs, exp_fetches);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
